alu_byte_sequencer: RTL and testbench

- Multi-cycle controller that runs one wide bitwise operation through the team's shared 8-bit ALU slice, one byte per cycle, LSB byte first.
- Accepts a full-width operand pair and a 2-bit op code over a valid/ready handshake.
- Drives the slice's operand and control inputs, collects each 8-bit result into a wide result register, then presents the result over a second valid/ready handshake.
- The ALU slice is instantiated outside this block and connected through the alu_* ports.

---
 rtl/alu_seq_pkg.sv | 14 +
 rtl/alu_byte_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_byte_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the byte-serial ALU sequencer: FSM state encoding
// and the lane/op-code widths of the external 8-bit ALU slice.
package alu_seq_pkg;

    localparam int BYTEW = 8;   // width of one ALU slice lane
    localparam int OPW   = 2;   // width of the slice control code

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_byte_sequencer.sv
// alu_byte_sequencer: runs one wide bitwise operation through an external
// 8-bit ALU slice, one byte per cycle, LSB byte first, and assembles the
// per-byte results into a wide result register.
//
// Optional build macro: ALU_SEQ_ZERO_FLAG_EN adds a registered 'zero'
// output that is 1 iff every captured result byte was 0x00.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. in_ready is high only in IDLE, so a
// request is taken exactly once; out_valid stays high with out_result held
// stable until the edge where out_ready is seen high. The producer may keep
// in_valid asserted across non-accepting cycles; it is simply ignored there.
module alu_byte_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BYTEW*NBYTES-1:0] in_a,
    input  logic [BYTEW*NBYTES-1:0] in_b,
    input  logic [OPW-1:0]          in_op,
    output logic [BYTEW-1:0]        alu_a,
    output logic [BYTEW-1:0]        alu_b,
    output logic [OPW-1:0]          alu_op,
    input  logic [BYTEW-1:0]        alu_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BYTEW*NBYTES-1:0] out_result,
    output logic                    busy,
    output state_t                  dbg_state
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic                    zero
`endif
);

    localparam int W    = BYTEW * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    state_t          state;
    logic [IDXW-1:0] idx;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [OPW-1:0]  op_reg;
    logic [W-1:0]    res_reg;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    // Sequencer FSM: capture request, walk the byte lanes, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= '0;
            res_reg     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg      <= in_a;
                        b_reg      <= in_b;
                        op_reg     <= in_op;
                        idx        <= '0;
                        res_reg    <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    res_reg[BYTEW*idx +: BYTEW] <= alu_result;
                    if (idx == LAST_IDX) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // The handover cycle back to IDLE never accepts: in_ready
                    // only rises once the FSM is already sitting in IDLE.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic zero_q;

    // Running AND of "result byte is zero" over the lanes of one operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            zero_q <= 1'b1;
        end else if (state == RUN) begin
            zero_q <= zero_q & (alu_result == '0);
        end
    end

    assign zero = zero_q;
`endif

    // Lane mux: the slice only sees captured operands, never in_a/in_b.
    assign alu_a = (state == RUN) ? a_reg[BYTEW*idx +: BYTEW] : '0;
    assign alu_b = (state == RUN) ? b_reg[BYTEW*idx +: BYTEW] : '0;

    assign alu_op     = op_reg;
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign out_result = res_reg;
    assign dbg_state  = state;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Bench for alu_byte_sequencer: a 4-lane instance driven from a vector table
// plus hand-written reset-abort sequence, and a 1-lane instance for the
// single-byte corner. The stub ALU slice is alu_result = alu_a ^ alu_b.
module tb_alu_byte_sequencer;
  import alu_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 4-lane DUT ----------------
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0]  in_op = '0;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        busy;
  state_t      dbg_state;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic        zero;
`endif

  assign alu_result = alu_a ^ alu_b;

  alu_byte_sequencer #(.NBYTES(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy), .dbg_state(dbg_state)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  // ---------------- 1-lane DUT ----------------
  logic       v1 = 1'b0;
  logic       r1;
  logic [7:0] a1 = '0;
  logic [7:0] b1 = '0;
  logic [1:0] op1 = '0;
  logic [7:0] alu_a1, alu_b1, alu_res1;
  logic [1:0] alu_op1;
  logic       ov1;
  logic       ordy1 = 1'b0;
  logic [7:0] res1;
  logic       busy1;
  state_t     dbg1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic       zero1;
`endif

  assign alu_res1 = alu_a1 ^ alu_b1;

  alu_byte_sequencer #(.NBYTES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(r1),
    .in_a(a1), .in_b(b1), .in_op(op1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_result(alu_res1),
    .out_valid(ov1), .out_ready(ordy1), .out_result(res1),
    .busy(busy1), .dbg_state(dbg1)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .zero(zero1)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One full operation on the 4-lane DUT. Inputs change and outputs are
  // sampled on the falling edge. hold = cycles of out_ready low in DONE;
  // perturb = scramble in_* and keep in_valid high after acceptance.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] exp, input logic exp_zero,
                        input int hold, input bit perturb);
    logic [31:0] want;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    out_ready = (hold == 0);
    exp_q.push_back(exp);
    @(negedge clk);
    if (perturb) begin
      in_a = 32'hDEADBEEF; in_b = 32'h0; in_op = ~op;
    end else begin
      in_valid = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      check("alu_a_lane", alu_a, a[8*k +: 8]);
      check("alu_b_lane", alu_b, b[8*k +: 8]);
      check("alu_op_run", alu_op, op);
      check("busy_run", busy, 1'b1);
      check("in_ready_run", in_ready, 1'b0);
      check("out_valid_run", out_valid, 1'b0);
      check("state_run", dbg_state, RUN);
      @(negedge clk);
    end
    want = exp_q.pop_front();
    check("out_valid_done", out_valid, 1'b1);
    check("out_result", out_result, want);
    check("in_ready_done", in_ready, 1'b0);
    check("alu_a_done", alu_a, 8'h00);
    check("alu_op_done", alu_op, op);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check("zero", zero, exp_zero);
`endif
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", out_valid, 1'b1);
        check("hold_result", out_result, want);
        check("hold_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("in_ready_after", in_ready, 1'b1);
    check("out_valid_after", out_valid, 1'b0);
    check("busy_after", busy, 1'b0);
    check("state_after", dbg_state, IDLE);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
    logic        zero;
    int          hold;
    bit          perturb;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h12345678, 32'hFFFFFFFF, 2'b10, 32'hEDCBA987, 1'b0, 5, 1'b0};
    vecs[1] = '{32'h12345678, 32'hFFFFFFFF, 2'b10, 32'hEDCBA987, 1'b0, 0, 1'b1};
    vecs[2] = '{32'hCAFEF00D, 32'hCAFEF00D, 2'b11, 32'h00000000, 1'b1, 0, 1'b0};
    vecs[3] = '{32'h00000100, 32'h00000000, 2'b01, 32'h00000100, 1'b0, 2, 1'b0};
    vecs[4] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 2'b00, 32'hFFFFFFFF, 1'b0, 0, 1'b0};
    vecs[5] = '{32'h0F0F0000, 32'h00F0F00F, 2'b01, 32'h0FFFF00F, 1'b0, 1, 1'b0};

    // reset state
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_op", alu_op, 2'b00);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].zero,
             vecs[i].hold, vecs[i].perturb);
    end

    // reset in the middle of RUN aborts the operation
    @(negedge clk);
    in_a = 32'h11223344; in_b = 32'h0; in_op = 2'b11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_run_lane0", alu_a, 8'h44);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_out_result", out_result, 32'h0);
    check("abort_busy", busy, 1'b0);
    check("abort_alu_op", alu_op, 2'b00);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 1'b0);
    end
    rst_n = 1'b1;
    run_op(32'h000000FF, 32'h0, 2'b00, 32'h000000FF, 1'b0, 0, 1'b0);

    // single-lane instance
    @(negedge clk);
    check("n1_in_ready", r1, 1'b1);
    a1 = 8'hA5; b1 = 8'h0F; op1 = 2'b01; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    check("n1_alu_a", alu_a1, 8'hA5);
    check("n1_alu_b", alu_b1, 8'h0F);
    check("n1_busy", busy1, 1'b1);
    check("n1_no_valid_yet", ov1, 1'b0);
    @(negedge clk);
    check("n1_out_valid", ov1, 1'b1);
    check("n1_out_result", res1, 8'hAA);
    check("n1_alu_op", alu_op1, 2'b01);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check("n1_zero", zero1, 1'b0);
`endif
    ordy1 = 1'b1;
    @(negedge clk);
    ordy1 = 1'b0;
    check("n1_in_ready_after", r1, 1'b1);
    check("n1_out_valid_after", ov1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
